// File: rtl/axis_fifo_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-aware round-robin AXIS arbiter.
package axis_arb_pkg;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axis_fifo_rr_arbiter_if.sv
// AXI-Stream bundle carrying N parallel lanes; N=1 with tid for the merged output.
interface axis_fifo_rr_arbiter_if #(
   parameter int N   = 1,
   parameter int DW  = 16,
   parameter int UW  = 1,
   parameter int IDW = 1
) ();
   logic [N*DW-1:0] tdata;
   logic [N*UW-1:0] tuser;
   logic [N-1:0]    tlast;
   logic [N-1:0]    tvalid;
   logic [N-1:0]    tready;
   logic [IDW-1:0]  tid;

   modport master (output tdata, output tuser, output tlast, output tvalid, output tid, input tready);
   modport slave  (input tdata, input tuser, input tlast, input tvalid, input tid, output tready);
endinterface

// File: rtl/axis_fifo_rr_arbiter_rr_next_grant.sv
// Picks the first requesting channel at or after rr_ptr, wrapping past NUM_CH-1.
module rr_next_grant #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   rr_ptr,
   output logic [CH_W-1:0]   grant_idx,
   output logic              any_req
);

   function automatic int wrap_idx(input int base, input int off);
      int sum;
      sum = base + off;
      return (sum >= NUM_CH) ? (sum - NUM_CH) : sum;
   endfunction

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      grant_idx = {CH_W{1'b0}};
      any_req   = |req;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         grant_idx = req[wrap_idx(int'(rr_ptr), i)] ? CH_W'(wrap_idx(int'(rr_ptr), i)) : grant_idx;
      end
   end

endmodule

// File: rtl/axis_fifo_rr_arbiter.sv
// Packet-locked round-robin merge of NUM_CH AXIS lanes onto one tagged stream.
// Optional in-packet watchdog enabled by defining AXIS_ARB_TIMEOUT_EN.
module axis_fifo_rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int DATA_WIDTH     = 16,
   parameter int USER_WIDTH     = 1,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   axis_fifo_rr_arbiter_if.slave   s_axis_in,
   axis_fifo_rr_arbiter_if.master  m_axis_out,
   output logic                    busy_o,
   output logic                    timeout_o
);

   localparam int CH_W = ch_w(NUM_CH);

   arb_state_t            r_state, w_state_nxt;
   logic [CH_W-1:0]       r_grant, w_grant_nxt;
   logic [CH_W-1:0]       r_rr_ptr, w_rr_ptr_nxt;
   logic [CH_W-1:0]       w_arb_idx;
   logic                  w_any_req;
   logic                  w_lane_open;
   logic                  w_accept;
   logic                  w_accept_last;
   logic                  w_release;
   logic [DATA_WIDTH-1:0] r_tdata;
   logic [USER_WIDTH-1:0] r_tuser;
   logic                  r_tlast;
   logic [CH_W-1:0]       r_tid;
   logic                  r_tvalid;

   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
      return (ch == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : (ch + CH_W'(1));
   endfunction

   rr_next_grant #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_rr_next_grant (
      .req       (s_axis_in.tvalid),
      .rr_ptr    (r_rr_ptr),
      .grant_idx (w_arb_idx),
      .any_req   (w_any_req)
   );

   // The granted lane may move a beat whenever the output register is free or draining.
   assign w_lane_open      = (r_state == LOCKED) && (!r_tvalid || m_axis_out.tready);
   assign w_accept         = w_lane_open && s_axis_in.tvalid[r_grant];
   assign w_accept_last    = w_accept && s_axis_in.tlast[r_grant];
   assign s_axis_in.tready = w_lane_open ? (NUM_CH'(1) << r_grant) : {NUM_CH{1'b0}};

`ifdef AXIS_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_timeout;

   assign w_release = (r_state == LOCKED) && !w_accept && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
   assign timeout_o = r_timeout;

   // Idle-cycle counter inside a locked packet plus the one-cycle release pulse.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_to_cnt  <= {TO_W{1'b0}};
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_release;
         if ((r_state != LOCKED) || w_accept || w_release) begin
            r_to_cnt <= {TO_W{1'b0}};
         end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
      end
   end
`else
   assign w_release = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // Next-state logic: lock on arbitration, unlock on the last beat or a watchdog release.
   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_rr_ptr_nxt = r_rr_ptr;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_state_nxt = LOCKED;
               w_grant_nxt = w_arb_idx;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         LOCKED: begin
            if (w_accept_last || w_release) begin
               w_state_nxt  = IDLE;
               w_rr_ptr_nxt = next_ch(r_grant);
            end else begin
               w_state_nxt = LOCKED;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM, grant and rotation pointer registers.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_state  <= IDLE;
         r_grant  <= {CH_W{1'b0}};
         r_rr_ptr <= {CH_W{1'b0}};
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
      end
   end

   // Output register: load on accept, hold while stalled, drop valid once drained.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_tdata  <= {DATA_WIDTH{1'b0}};
         r_tuser  <= {USER_WIDTH{1'b0}};
         r_tlast  <= 1'b0;
         r_tid    <= {CH_W{1'b0}};
         r_tvalid <= 1'b0;
      end else if (w_accept) begin
         r_tdata  <= s_axis_in.tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
         r_tuser  <= s_axis_in.tuser[r_grant*USER_WIDTH +: USER_WIDTH];
         r_tlast  <= s_axis_in.tlast[r_grant];
         r_tid    <= r_grant;
         r_tvalid <= 1'b1;
      end else if (m_axis_out.tready) begin
         r_tvalid <= 1'b0;
      end else begin
         r_tvalid <= r_tvalid;
      end
   end

   assign m_axis_out.tdata  = r_tdata;
   assign m_axis_out.tuser  = r_tuser;
   assign m_axis_out.tlast  = r_tlast;
   assign m_axis_out.tid    = r_tid;
   assign m_axis_out.tvalid = r_tvalid;
   assign busy_o            = (r_state == LOCKED);

endmodule

// File: tb/tb_axis_fifo_rr_arbiter.sv
// Scoreboard bench for axis_fifo_rr_arbiter: per-lane source queues, expected-beat queue, output monitor.
module tb_axis_fifo_rr_arbiter;
   import axis_arb_pkg::*;

   localparam int NUM_CH = 4;
   localparam int DW     = 16;
   localparam int UW     = 1;
   localparam int CH_W   = 2;

   typedef struct packed {
      logic [DW-1:0]   d;
      logic            u;
      logic            l;
      logic [CH_W-1:0] id;
   } beat_t;

   logic clk = 1'b0;
   logic reset_ni = 1'b0;
   logic busy_o;
   logic timeout_o;

   always #5 clk = ~clk;

   axis_fifo_rr_arbiter_if #(.N(NUM_CH), .DW(DW), .UW(UW), .IDW(CH_W)) s_if ();
   axis_fifo_rr_arbiter_if #(.N(1),      .DW(DW), .UW(UW), .IDW(CH_W)) m_if ();

   axis_fifo_rr_arbiter #(
      .NUM_CH         (NUM_CH),
      .DATA_WIDTH     (DW),
      .USER_WIDTH     (UW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i      (clk),
      .reset_ni   (reset_ni),
      .s_axis_in  (s_if),
      .m_axis_out (m_if),
      .busy_o     (busy_o),
      .timeout_o  (timeout_o)
   );

   beat_t             src_q[NUM_CH][$];
   beat_t             sb_q[$];
   beat_t             mon_exp;
   beat_t             held;
   bit                hold_v = 1'b0;
   int                out_cyc[$];
   int                n_vec = 0;
   int                n_err = 0;
   int                cyc = 0;
   int                to_pulses = 0;
   int                k0;
   int                wait_k;
   logic [NUM_CH-1:0] fire = '0;
   logic              tpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic bit src_busy();
      bit b = 1'b0;
      for (int c = 0; c < NUM_CH; c++) b |= (src_q[c].size() != 0);
      return b;
   endfunction

   // Packet of n beats data base..base+n-1, tuser = data bit 0, tlast on final beat if has_last.
   task automatic pkt(input int c, input logic [DW-1:0] base, input int n,
                      input bit to_src, input bit to_exp, input bit has_last);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.d  = base + DW'(i);
         b.u  = b.d[0];
         b.l  = has_last && (i == n - 1);
         b.id = CH_W'(c);
         if (to_src) src_q[c].push_back(b);
         if (to_exp) sb_q.push_back(b);
      end
   endtask

   task automatic drain(input string name, input int budget);
      int k = 0;
      while ((sb_q.size() != 0 || src_busy()) && k < budget) begin
         @(posedge clk);
         k++;
      end
      if (k >= budget) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: %0d beats outstanding, expected 0", name, sb_q.size());
      end
      repeat (3) @(posedge clk);
      #2;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Handshakes are decided by the values visible between negedge and the next posedge.
   initial forever begin
      @(negedge clk);
      fire = reset_ni ? (s_if.tvalid & s_if.tready) : '0;
   end

   initial begin
      s_if.tdata  = '0;
      s_if.tuser  = '0;
      s_if.tlast  = '0;
      s_if.tvalid = '0;
      s_if.tid    = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int c = 0; c < NUM_CH; c++) begin
            if (fire[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
            if (src_q[c].size() > 0) begin
               s_if.tvalid[c]          = 1'b1;
               s_if.tdata[c*DW +: DW]  = src_q[c][0].d;
               s_if.tuser[c*UW +: UW]  = src_q[c][0].u;
               s_if.tlast[c]           = src_q[c][0].l;
            end else begin
               s_if.tvalid[c]          = 1'b0;
               s_if.tdata[c*DW +: DW]  = '0;
               s_if.tuser[c*UW +: UW]  = '0;
               s_if.tlast[c]           = 1'b0;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (timeout_o) to_pulses++;
      if (reset_ni) begin
         if (hold_v) chk("stall_hold", {m_if.tdata, m_if.tlast, m_if.tid}, {held.d, held.l, held.id});
         if (m_if.tvalid && !m_if.tready && (|s_if.tvalid)) chk("stall_tready", 32'(s_if.tready), 32'd0);
         if (m_if.tvalid && m_if.tready) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_beat: got 0x%0h tid %0d, expected no beat", m_if.tdata, m_if.tid);
            end else begin
               mon_exp = sb_q.pop_front();
               chk("out_beat", {m_if.tdata, m_if.tuser, m_if.tlast, m_if.tid}, mon_exp);
               out_cyc.push_back(cyc);
            end
         end
         hold_v = m_if.tvalid && !m_if.tready;
         held   = {m_if.tdata, m_if.tuser, m_if.tlast, m_if.tid};
      end else begin
         hold_v = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      m_if.tready = 1'b0;
      reset_ni    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid",  32'(m_if.tvalid), 32'd0);
      chk("rst_tdata",   32'(m_if.tdata),  32'd0);
      chk("rst_s_tready", 32'(s_if.tready), 32'd0);
      chk("rst_busy",    32'(busy_o),      32'd0);
      chk("rst_timeout", 32'(timeout_o),   32'd0);
      @(posedge clk);
      #2;
      reset_ni    = 1'b1;
      m_if.tready = 1'b1;

      // Round robin from ptr 0: ch0, ch2, ch3, then wrap back to ch0's second packet.
      pkt(0, 16'h00A0, 2, 1'b1, 1'b1, 1'b1);
      pkt(0, 16'h00A2, 2, 1'b1, 1'b0, 1'b1);
      pkt(2, 16'h00C0, 2, 1'b1, 1'b1, 1'b1);
      pkt(3, 16'h00D0, 2, 1'b1, 1'b1, 1'b1);
      pkt(0, 16'h00A2, 2, 1'b0, 1'b1, 1'b1);
      drain("rr_order", 200);

      // Single ch1 packet: tvalid appears after edge k0+1, first beat out after edge k0+3.
      @(posedge clk);
      #2;
      k0 = cyc;
      out_cyc.delete();
      pkt(1, 16'h0011, 4, 1'b1, 1'b1, 1'b1);
      drain("single_pkt", 100);
      chk("beat_count",     32'(out_cyc.size()),           32'd4);
      chk("lat_first",      32'(out_cyc[0] - k0),          32'd3);
      chk("lat_last_nogap", 32'(out_cyc[3] - out_cyc[0]),  32'd3);

      // Downstream backpressure 1,0,0,1 during a ch2 packet.
      pkt(2, 16'h0031, 4, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #2;
         m_if.tready = tpat[i % 4];
      end
      m_if.tready = 1'b1;
      drain("stall_pkt", 100);

      // ch0 requests while ch3 holds the lock.
      pkt(3, 16'h0041, 3, 1'b1, 1'b1, 1'b1);
      pkt(0, 16'h004A, 2, 1'b0, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      pkt(0, 16'h004A, 2, 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk("no_preempt_tready0", 32'(s_if.tready[0]), 32'd0);
      chk("lock_tready",        32'(s_if.tready),    32'h8);
      chk("no_preempt_busy",    32'(busy_o),         32'd1);
      drain("no_preempt", 100);

      // Reset while the 2nd beat of a 5-beat ch0 packet is offered.
      pkt(0, 16'h0051, 5, 1'b1, 1'b0, 1'b1);
      pkt(0, 16'h0051, 1, 1'b0, 1'b1, 1'b0);
      wait_k = 0;
      while (sb_q.size() != 0 && wait_k < 50) begin
         @(negedge clk);
         #2;
         wait_k++;
      end
      chk("rst_pkt_first_beat_seen", 32'(wait_k < 50), 32'd1);
      reset_ni = 1'b0;
      src_q[0].delete();
      @(posedge clk);
      #2;
      reset_ni = 1'b1;
      @(negedge clk);
      chk("mid_rst_tvalid",  32'(m_if.tvalid), 32'd0);
      chk("mid_rst_tdata",   32'(m_if.tdata),  32'd0);
      chk("mid_rst_tlast",   32'(m_if.tlast),  32'd0);
      chk("mid_rst_tid",     32'(m_if.tid),    32'd0);
      chk("mid_rst_s_tready", 32'(s_if.tready), 32'd0);
      chk("mid_rst_busy",    32'(busy_o),      32'd0);
      // rr_ptr back at 0 means ch0 beats ch1 despite the pre-reset pointer of 1.
      pkt(1, 16'h0061, 2, 1'b1, 1'b0, 1'b1);
      pkt(0, 16'h0071, 2, 1'b1, 1'b1, 1'b1);
      pkt(1, 16'h0061, 2, 1'b0, 1'b1, 1'b1);
      drain("post_rst_order", 100);

`ifdef AXIS_ARB_TIMEOUT_EN
      // ch2 stalls after one beat; watchdog hands the lane to pending ch3.
      to_pulses = 0;
      pkt(2, 16'h0081, 1, 1'b1, 1'b1, 1'b0);
      pkt(3, 16'h0091, 2, 1'b1, 1'b1, 1'b1);
      drain("timeout_release", 100);
      chk("timeout_pulse", 32'(to_pulses), 32'd1);
`else
      chk("timeout_tied0", 32'(to_pulses), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
